// File: rtl/data_cache_m_pkg.sv
// +----------------------------------------------------------------------+
// | data_cache_m_pkg : shared types/constants for the M-stage data cache |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package data_cache_m_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REFILL     = 2'd1,
    ST_WRITE_THRU = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 2;

  // Unlisted funct3 encodings fall back to a full-word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_cache_m_if.sv
// +----------------------------------------------------------------------+
// | data_cache_m_if : main-memory req/ack word interface                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface data_cache_m_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

`default_nettype wire

// File: rtl/data_cache_m_lane_align.sv
// +----------------------------------------------------------------------+
// | data_cache_m_lane_align : store lane steering and load extension     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module data_cache_m_lane_align
  import data_cache_m_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        zero_ext;

  always_comb begin
    load_byte = load_word[{offset, 3'b000} +: 8];
    load_half = load_word[{offset[1], 4'b0000} +: 16];
    zero_ext  = funct3[2];
    wstrb     = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    case (f3_size(funct3))
      SZ_B: begin
        wstrb     = 4'b0001 << offset;
        wdata     = {24'b0, store_data[7:0]} << {offset, 3'b000};
        load_data = zero_ext ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
      end
      // Halfword ignores addr[0]: the lane is picked by addr[1] only.
      SZ_H: begin
        wstrb     = 4'b0011 << {offset[1], 1'b0};
        wdata     = {16'b0, store_data[15:0]} << {offset[1], 4'b0000};
        load_data = zero_ext ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_cache_m.sv
// +----------------------------------------------------------------------+
// | data_cache_m : direct-mapped write-through no-allocate data cache    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module data_cache_m
  import data_cache_m_pkg::*;
#(
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemReadM_i,
  input  logic          MemWriteM_i,
  input  logic [2:0]    Funct3M_i,
  input  logic [31:0]   ALUResultM_i,
  input  logic [31:0]   WriteDataM_i,
  output logic [31:0]   ReadDataM_o,
  output logic          StallM_o,
  data_cache_m_if.master mem
);

  localparam int WOFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int CNT_W   = clog2_min1(LINE_WORDS);
  localparam int TAG_LSB = OFFSET_W + WOFF_W + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  state_e             state, next_state;
  logic [CNT_W-1:0]   fill_cnt;
  logic [CNT_W-1:0]   word_sel;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [31:0]        fill_addr;
  logic [31:0]        cached_word;
  logic [31:0]        lane_wdata;
  logic [31:0]        load_ext;
  logic [3:0]         lane_wstrb;
  logic               hit;
  logic               is_load;
  logic               is_store;
  logic               fill_we;
  logic               set_valid;
  logic               merge_we;

  logic [31:0]        data_mem [SETS][LINE_WORDS];
  logic [TAG_W-1:0]   tag_mem  [SETS];
  logic [SETS-1:0]    valid;

  assign idx = ALUResultM_i[OFFSET_W + WOFF_W +: IDX_W];
  assign tag = ALUResultM_i[ADDR_W-1:TAG_LSB];

  generate
    if (WOFF_W > 0) begin : g_multi_word
      assign word_sel  = ALUResultM_i[OFFSET_W +: WOFF_W];
      assign fill_addr = {ALUResultM_i[ADDR_W-1:OFFSET_W + WOFF_W], fill_cnt, 2'b00};
    end else begin : g_single_word
      assign word_sel  = '0;
      assign fill_addr = {ALUResultM_i[ADDR_W-1:OFFSET_W], 2'b00};
    end
  endgenerate

  // A simultaneous read+write request is handled as a store.
  assign is_store    = MemWriteM_i;
  assign is_load     = MemReadM_i & ~MemWriteM_i;
  assign hit         = valid[idx] && (tag_mem[idx] == tag);
  assign cached_word = data_mem[idx][word_sel];

  data_cache_m_lane_align u_lane_align (
    .funct3     (Funct3M_i),
    .offset     (ALUResultM_i[1:0]),
    .store_data (WriteDataM_i),
    .load_word  (cached_word),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .load_data  (load_ext)
  );

  always_comb begin
    next_state      = state;
    StallM_o        = 1'b0;
    ReadDataM_o     = '0;
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = {ALUResultM_i[ADDR_W-1:OFFSET_W], 2'b00};
    mem.mem_wdata_o = lane_wdata;
    mem.mem_wstrb_o = '0;
    fill_we         = 1'b0;
    set_valid       = 1'b0;
    merge_we        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_store) begin
          StallM_o   = 1'b1;
          next_state = ST_WRITE_THRU;
        end else if (is_load) begin
          if (hit) begin
            ReadDataM_o = load_ext;
          end else begin
            StallM_o   = 1'b1;
            next_state = ST_REFILL;
          end
        end
      end
      // The load re-looks-up in IDLE after the last word lands and hits there.
      ST_REFILL: begin
        StallM_o       = 1'b1;
        mem.mem_req_o  = 1'b1;
        mem.mem_addr_o = fill_addr;
        if (mem.mem_ack_i) begin
          fill_we = 1'b1;
          if (fill_cnt == LAST_WORD) begin
            set_valid  = 1'b1;
            next_state = ST_IDLE;
          end
        end
      end
      ST_WRITE_THRU: begin
        mem.mem_req_o   = 1'b1;
        mem.mem_we_o    = 1'b1;
        mem.mem_wstrb_o = lane_wstrb;
        StallM_o        = ~mem.mem_ack_i;
        if (mem.mem_ack_i) begin
          merge_we   = hit;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fill_cnt <= '0;
      valid    <= '0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && next_state == ST_REFILL) begin
        fill_cnt <= '0;
      end else if (fill_we) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
      end
      if (set_valid) begin
        valid[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we) begin
        data_mem[idx][fill_cnt] <= mem.mem_rdata_i;
      end
      if (set_valid) begin
        tag_mem[idx] <= tag;
      end
      if (merge_we) begin
        for (int b = 0; b < 4; b++) begin
          if (lane_wstrb[b]) begin
            data_mem[idx][word_sel][8*b +: 8] <= lane_wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_cache_m.sv
// +----------------------------------------------------------------------+
// | tb_data_cache_m : directed bench with a word-addressed memory model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_data_cache_m;
  import data_cache_m_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en, wr_en;
  logic [2:0]  f3;
  logic [31:0] addr, wdat;
  logic [31:0] rdata;
  logic        stall;

  data_cache_m_if bus ();

  data_cache_m #(.SETS(256), .LINE_WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemReadM_i   (rd_en),
    .MemWriteM_i  (wr_en),
    .Funct3M_i    (f3),
    .ALUResultM_i (addr),
    .WriteDataM_i (wdat),
    .ReadDataM_o  (rdata),
    .StallM_o     (stall),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] log_addr  [$];
  logic        log_we    [$];
  logic [3:0]  log_strb  [$];
  logic [31:0] log_wdata [$];

  function automatic logic [31:0] read_mem(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: one idle cycle of latency, then a one-cycle ack.
  initial begin
    int wait_c;
    logic [31:0] w;
    wait_c = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst || bus.mem_ack_i) begin
        bus.mem_ack_i = 1'b0;
        wait_c = 0;
      end else if (bus.mem_req_o) begin
        if (wait_c >= 1) begin
          bus.mem_ack_i = 1'b1;
          ack_cnt++;
          log_addr.push_back(bus.mem_addr_o);
          log_we.push_back(bus.mem_we_o);
          log_strb.push_back(bus.mem_wstrb_o);
          log_wdata.push_back(bus.mem_wdata_o);
          if (bus.mem_we_o) begin
            w = read_mem(bus.mem_addr_o);
            for (int b = 0; b < 4; b++)
              if (bus.mem_wstrb_o[b]) w[8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
            mem_model[bus.mem_addr_o] = w;
          end else begin
            bus.mem_rdata_i = read_mem(bus.mem_addr_o);
          end
        end else begin
          wait_c++;
        end
      end else begin
        wait_c = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one M-stage access, hold it while stalled, retire it on the release edge.
  task automatic access(input logic r, input logic w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd_out, output logic first_stall,
                        output logic first_req);
    int budget;
    rd_en = r; wr_en = w; f3 = fn; addr = a; wdat = d;
    @(negedge clk); #1;
    first_stall = stall;
    first_req   = bus.mem_req_o;
    budget = 0;
    while (stall && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    chk("stall_release", 32'(stall), 32'd0);
    rd_out = rdata;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic        fs, fr;
    int          base, abase, budget;

    rd_en = 1'b0; wr_en = 1'b0; f3 = F3_W; addr = '0; wdat = '0;
    mem_model[32'h100] = 32'hDEAD_BEEF;
    mem_model[32'h104] = 32'h0BAD_F00D;
    mem_model[32'h108] = 32'h1357_9BDF;
    mem_model[32'h10C] = 32'h2468_ACE0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req",   32'(bus.mem_req_o), 32'd0);
    chk("rst_we",    32'(bus.mem_we_o), 32'd0);
    chk("rst_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold load: four refill reads, then the hit.
    base = log_addr.size();
    access(1'b1, 1'b0, F3_W, 32'h100, 32'h0, v, fs, fr);
    chk("cold_first_stall", 32'(fs), 32'd1);
    chk("cold_data", v, 32'hDEAD_BEEF);
    chk("cold_nreq", 32'(log_addr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cold_addr", log_addr[base+i], 32'h100 + 32'(4*i));
      chk("cold_we",   32'(log_we[base+i]), 32'd0);
    end

    // Hit in the filled line: no stall, no request.
    base = log_addr.size();
    access(1'b1, 1'b0, F3_W, 32'h104, 32'h0, v, fs, fr);
    chk("hit_stall", 32'(fs), 32'd0);
    chk("hit_req",   32'(fr), 32'd0);
    chk("hit_data",  v, 32'h0BAD_F00D);
    chk("hit_nreq",  32'(log_addr.size() - base), 32'd0);

    // Store hit, byte store, byte loads.
    base = log_addr.size();
    access(1'b0, 1'b1, F3_W, 32'h100, 32'h1122_3344, v, fs, fr);
    chk("sw_stall", 32'(fs), 32'd1);
    chk("sw_nreq",  32'(log_addr.size() - base), 32'd1);
    chk("sw_strb",  32'(log_strb[base]), 32'hF);
    chk("sw_we",    32'(log_we[base]), 32'd1);
    access(1'b1, 1'b0, F3_W, 32'h100, 32'h0, v, fs, fr);
    chk("sw_reload", v, 32'h1122_3344);
    chk("sw_reload_stall", 32'(fs), 32'd0);
    base = log_addr.size();
    access(1'b0, 1'b1, F3_B, 32'h101, 32'h0000_00A5, v, fs, fr);
    chk("sb_addr",  log_addr[base], 32'h100);
    chk("sb_strb",  32'(log_strb[base]), 32'h2);
    chk("sb_wdata", log_wdata[base], 32'h0000_A500);
    access(1'b1, 1'b0, F3_BU, 32'h101, 32'h0, v, fs, fr);
    chk("lbu", v, 32'h0000_00A5);
    access(1'b1, 1'b0, F3_B, 32'h101, 32'h0, v, fs, fr);
    chk("lb", v, 32'hFFFF_FFA5);
    access(1'b1, 1'b0, F3_W, 32'h100, 32'h0, v, fs, fr);
    chk("sb_merge", v, 32'h1122_A544);
    base = log_addr.size();
    access(1'b0, 1'b1, F3_H, 32'h10E, 32'h0000_BEEF, v, fs, fr);
    chk("sh_addr",  log_addr[base], 32'h10C);
    chk("sh_strb",  32'(log_strb[base]), 32'hC);
    chk("sh_wdata", log_wdata[base], 32'hBEEF_0000);
    access(1'b1, 1'b0, F3_W, 32'h10C, 32'h0, v, fs, fr);
    chk("sh_merge", v, 32'hBEEF_ACE0);

    // Store miss does not allocate.
    base = log_addr.size();
    access(1'b0, 1'b1, F3_W, 32'h2000, 32'hCAFE_F00D, v, fs, fr);
    chk("swmiss_nreq",  32'(log_addr.size() - base), 32'd1);
    chk("swmiss_addr",  log_addr[base], 32'h2000);
    chk("swmiss_wdata", log_wdata[base], 32'hCAFE_F00D);
    base = log_addr.size();
    access(1'b1, 1'b0, F3_W, 32'h2000, 32'h0, v, fs, fr);
    chk("noalloc_stall", 32'(fs), 32'd1);
    chk("noalloc_nreq",  32'(log_addr.size() - base), 32'd4);
    chk("noalloc_data",  v, 32'hCAFE_F00D);

    // Read and write together behave as a store.
    base = log_addr.size();
    access(1'b1, 1'b1, F3_W, 32'h108, 32'h55AA_55AA, v, fs, fr);
    chk("rdwr_nreq", 32'(log_addr.size() - base), 32'd1);
    chk("rdwr_we",   32'(log_we[base]), 32'd1);
    access(1'b1, 1'b0, F3_W, 32'h108, 32'h0, v, fs, fr);
    chk("rdwr_data", v, 32'h55AA_55AA);

    // Halfword and odd-funct3 loads.
    access(1'b0, 1'b1, F3_W, 32'h100, 32'h8001_0000, v, fs, fr);
    access(1'b1, 1'b0, F3_H, 32'h102, 32'h0, v, fs, fr);
    chk("lh_hi", v, 32'hFFFF_8001);
    access(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, v, fs, fr);
    chk("lhu_hi", v, 32'h0000_8001);
    access(1'b1, 1'b0, F3_H, 32'h103, 32'h0, v, fs, fr);
    chk("lh_odd", v, 32'hFFFF_8001);
    access(1'b1, 1'b0, F3_B, 32'h103, 32'h0, v, fs, fr);
    chk("lb_b3", v, 32'hFFFF_FF80);
    access(1'b1, 1'b0, F3_H, 32'h100, 32'h0, v, fs, fr);
    chk("lh_lo", v, 32'h0000_0000);
    access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, v, fs, fr);
    chk("f3_other", v, 32'h8001_0000);

    // Reset in the middle of a refill.
    rd_en = 1'b1; wr_en = 1'b0; f3 = F3_W; addr = 32'h300;
    abase = ack_cnt;
    budget = 0;
    while (ack_cnt < abase + 2 && budget < 100) begin
      @(negedge clk); #1;
      budget++;
    end
    chk("rst_mid_acks", 32'(ack_cnt - abase), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1; rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_req",   32'(bus.mem_req_o), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    base = log_addr.size();
    access(1'b1, 1'b0, F3_W, 32'h300, 32'h0, v, fs, fr);
    chk("rst_reload_stall", 32'(fs), 32'd1);
    chk("rst_reload_nreq",  32'(log_addr.size() - base), 32'd4);
    chk("rst_reload_data",  v, 32'h5A5A_0300);
    access(1'b1, 1'b0, F3_W, 32'h100, 32'h0, v, fs, fr);
    chk("rst_inval_stall", 32'(fs), 32'd1);
    chk("rst_inval_data",  v, 32'h8001_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
